// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two requesters.
// Each grant sends a 3-byte frame (header, data[15:8], data[7:0]) and ends with a one-cycle ack.
module uart_tx_arbiter #(
  parameter logic [3:0] HDR_NIBBLE = 4'hA
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  input  logic        tx_busy,
  output logic [7:0]  tx_din,
  output logic        tx_wr_en,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshakes: reqN is a level held by the requester until its one-cycle ackN pulse;
  // a byte is handed to the UART by a one-cycle tx_wr_en with tx_din stable until tx_busy
  // rises, and the next byte is only offered once tx_busy has fallen again.

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] STROBE     = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] ACK        = 3'd4;

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  logic        last_src;
  logic        src_id;
  logic [15:0] payload;
  logic        grant;
  logic        grant_src;

  assign state_dbg = state;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = !tx_busy && (req0 || req1);
    if (req0 && req1) grant_src = ~last_src;
    else              grant_src = req1;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
      last_src <= 1'b1;
      src_id   <= 1'b0;
      payload  <= 16'h0000;
      tx_din   <= 8'h00;
      tx_wr_en <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_wr_en <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            src_id   <= grant_src;
            last_src <= grant_src;
            payload  <= grant_src ? data1 : data0;
            byte_idx <= 2'd0;
            tx_din   <= {HDR_NIBBLE, 3'b000, grant_src};
            tx_wr_en <= 1'b1;
            busy     <= 1'b1;
            state    <= STROBE;
          end
        end
        STROBE: state <= WAIT_START;
        WAIT_START: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (byte_idx != 2'd2) begin
              byte_idx <= byte_idx + 2'd1;
              tx_din   <= (byte_idx == 2'd0) ? payload[15:8] : payload[7:0];
              tx_wr_en <= 1'b1;
              state    <= STROBE;
            end else begin
              ack0  <= ~src_id;
              ack1  <= src_id;
              state <= ACK;
            end
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural UART model.
// Stimulus pushes expected bytes/acks; a monitor pops and compares on each strobe and ack.
module tb_uart_tx_arbiter;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] data0 = 16'h0000, data1 = 16'h0000;
  logic        ack0, ack1, tx_wr_en, busy;
  logic [7:0]  tx_din;
  logic [2:0]  state_dbg;
  logic        uart_busy = 1'b0, ext_busy = 1'b0;
  logic        tx_busy;

  assign tx_busy = uart_busy | ext_busy;

  uart_tx_arbiter #(.HDR_NIBBLE(4'hA)) dut (
    .pclk(pclk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx_busy(tx_busy), .tx_din(tx_din), .tx_wr_en(tx_wr_en),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [0:0] ack_q[$];
  int  strobes = 0;
  int  busy_len = 20;
  bit  last = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arbitration rule: lone requester wins, tie goes to the one not served last.
  function automatic bit winner(input bit r0, input bit r1, input bit l);
    if (r0 && r1) return ~l;
    return r1;
  endfunction

  task automatic push_bytes(input bit src, input logic [15:0] d);
    exp_q.push_back({4'hA, 3'b000, src});
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic push_frame(input bit src, input logic [15:0] d);
    push_bytes(src, d);
    ack_q.push_back(src);
  endtask

  task automatic cycle();
    @(posedge pclk); #1;
  endtask

  task automatic reset_dut();
    cycle(); rst = 1'b1;
    cycle(); rst = 1'b0;
    last = 1'b1;
  endtask

  task automatic wait_acks(input bit n0, input bit n1);
    int c = 0;
    while ((n0 || n1) && c < 2000) begin
      cycle(); c++;
      if (ack0 && n0) begin req0 = 1'b0; n0 = 1'b0; end
      if (ack1 && n1) begin req1 = 1'b0; n1 = 1'b0; end
    end
    check("ack_timeout", {31'd0, n0 | n1}, 32'd0);
  endtask

  task automatic wait_n_acks(input int n);
    int c = 0;
    int got = 0;
    while (got < n && c < 4000) begin
      cycle(); c++;
      if (ack0 || ack1) got++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("ack_count_timeout", got, n);
  endtask

  // UART model + scoreboard monitor: busy rises one cycle after a strobe, for busy_len cycles.
  initial begin
    bit prev_wr = 1'b0, prev_a0 = 1'b0, prev_a1 = 1'b0;
    bit pending = 1'b0;
    int cnt = 0;
    logic [7:0] held = 8'h00;
    logic [0:0] exp_src;
    forever begin
      cycle();
      if (uart_busy) begin
        cnt--;
        if (cnt <= 0) uart_busy = 1'b0;
      end
      if (pending) begin
        check("din_stable", tx_din, held);
        uart_busy = 1'b1;
        cnt = busy_len;
        pending = 1'b0;
      end
      if (tx_wr_en) begin
        check("single_strobe", {31'd0, prev_wr}, 32'd0);
        check("strobe_while_busy", {31'd0, tx_busy}, 32'd0);
        check("busy_on_strobe", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got byte %h expected none", tx_din);
        end else begin
          check("tx_byte", tx_din, exp_q.pop_front());
        end
        held = tx_din;
        pending = 1'b1;
        strobes++;
      end
      if (ack0 || ack1) begin
        check("ack_both", {31'd0, ack0 & ack1}, 32'd0);
        check("ack_pulse_width", {30'd0, prev_a1 & ack1, prev_a0 & ack0}, 32'd0);
        if (!(prev_a0 && ack0) && !(prev_a1 && ack1)) begin
          if (ack_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none", ack0, ack1);
          end else begin
            exp_src = ack_q.pop_front();
            check("ack_src", {31'd0, ack1}, {31'd0, exp_src});
          end
        end
      end
      prev_wr = tx_wr_en;
      prev_a0 = ack0;
      prev_a1 = ack1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d, d2;
    bit w;
    int s0, c;
    int p;

    repeat (3) cycle();
    rst = 1'b0;
    check("rst_tx_din", tx_din, 8'h00);
    check("rst_tx_wr_en", {31'd0, tx_wr_en}, 32'd0);
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single requester, directed payload.
    busy_len = 20;
    push_frame(0, 16'h1234); last = 1'b0;
    data0 = 16'h1234; req0 = 1'b1;
    wait_acks(1, 0);

    // Simultaneous requests right after reset: requester 0 first.
    reset_dut();
    d = 16'($urandom);
    w = winner(1, 1, last); push_frame(w, w ? 16'hBEEF : d);
    push_frame(~w, ~w ? 16'hBEEF : d); last = ~w;
    data0 = d; data1 = 16'hBEEF;
    req0 = 1'b1; req1 = 1'b1;
    wait_acks(1, 1);

    // Both held continuously for 4 frames.
    busy_len = 3;
    data0 = 16'($urandom); data1 = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      w = winner(1, 1, last);
      push_frame(w, w ? data1 : data0);
      last = w;
    end
    req0 = 1'b1; req1 = 1'b1;
    wait_n_acks(4);
    repeat (3) cycle();

    // Requester 1 drops req and changes payload right after its grant.
    push_frame(1, 16'h5A5A); last = 1'b1;
    data1 = 16'h5A5A; req1 = 1'b1;
    c = 0;
    while (!tx_wr_en && c < 200) begin cycle(); c++; end
    check("grant_timeout", {31'd0, tx_wr_en}, 32'd1);
    req1 = 1'b0; data1 = 16'h0000;
    wait_n_acks(1);

    // Reset while waiting on the last byte: no ack, next grant waits for the UART.
    busy_len = 20;
    d = 16'($urandom);
    push_bytes(0, d);
    data0 = d; req0 = 1'b1; s0 = strobes;
    c = 0;
    while (strobes < s0 + 3 && c < 1000) begin cycle(); c++; end
    while (!uart_busy && c < 1000) begin cycle(); c++; end
    check("abort_setup_timeout", {31'd0, uart_busy}, 32'd1);
    repeat (2) cycle();
    rst = 1'b1;
    cycle(); rst = 1'b0; last = 1'b1;
    check("abort_tx_din", tx_din, 8'h00);
    check("abort_tx_wr_en", {31'd0, tx_wr_en}, 32'd0);
    check("abort_ack0", {31'd0, ack0}, 32'd0);
    check("abort_ack1", {31'd0, ack1}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    d2 = 16'($urandom);
    data0 = d2;
    push_frame(0, d2); last = 1'b0;
    wait_acks(1, 0);

    // Foreign transmission in progress: grant only after tx_busy falls.
    repeat (2) cycle();
    ext_busy = 1'b1;
    d = 16'($urandom);
    push_frame(0, d); last = 1'b0;
    data0 = d; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("hold_while_busy", {31'd0, tx_wr_en}, 32'd0);
    end
    ext_busy = 1'b0;
    cycle();
    check("strobe_after_fall", {31'd0, tx_wr_en}, 32'd1);
    wait_acks(1, 0);

    // Randomized request patterns, payloads and UART busy lengths.
    for (int it = 0; it < 10; it++) begin
      p = $urandom_range(1, 3);
      busy_len = $urandom_range(1, 6);
      data0 = 16'($urandom); data1 = 16'($urandom);
      w = winner(p[0], p[1], last);
      push_frame(w, w ? data1 : data0);
      last = w;
      if (p == 3) begin
        push_frame(~w, ~w ? data1 : data0);
        last = ~w;
      end
      req0 = p[0]; req1 = p[1];
      wait_acks(p[0], p[1]);
      repeat ($urandom_range(0, 3)) cycle();
    end

    repeat (10) cycle();
    check("bytes_left", exp_q.size(), 0);
    check("acks_left", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
